// File: rtl/router_ctrl_fsm_if.sv
// Control-path bundle between the 1xN router packet FSM and its neighbours.
// Latency: none, wires only.
// Backpressure: fifo_full and the per-channel empty flags flow towards the FSM; busy flows back to the source.
//
// Ports (master = FSM side, slave = source / FIFO / register-block side):
//   pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid : into the FSM
//   write_enb_reg, detect_add, ld_state, laf_state, lfd_state, full_state,
//   rst_int_reg, busy, drop_state, ch_sel, timeout_err, addr_err                     : out of the FSM
interface router_ctrl_fsm_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
);
  logic              pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic              fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] soft_reset;
  logic              parity_done;
  logic              low_pkt_valid;

  logic              write_enb_reg;
  logic              detect_add;
  logic              ld_state;
  logic              laf_state;
  logic              lfd_state;
  logic              full_state;
  logic              rst_int_reg;
  logic              busy;
  logic              drop_state;
  logic [NUM_CH-1:0] ch_sel;
  logic              timeout_err;
  logic              addr_err;

  modport master (
    input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
    output write_enb_reg, detect_add, ld_state, laf_state, lfd_state, full_state,
           rst_int_reg, busy, drop_state, ch_sel, timeout_err, addr_err
  );

  modport slave (
    output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
    input  write_enb_reg, detect_add, ld_state, laf_state, lfd_state, full_state,
           rst_int_reg, busy, drop_state, ch_sel, timeout_err, addr_err
  );
endinterface

// File: rtl/router_ctrl_fsm.sv
// Packet-control FSM for the 1xN router: decodes header address, sequences header/payload/parity writes.
// Latency: header accepted at cycle N gives lfd_state at N+1 and ld_state at N+2; all decodes are Moore.
// Backpressure: busy stalls the source; fifo_full parks the FSM in FIFO_FULL_STATE until space frees.
//
// Ports:
//   clock   : sole clock, rising edge
//   resetn  : asynchronous active-low reset
//   ctrl_if : router_ctrl_fsm_if.master (handshake inputs, state decodes, ch_sel, error pulses)
module router_ctrl_fsm #(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 30
) (
  input logic               clock,
  input logic               resetn,
  router_ctrl_fsm_if.master ctrl_if
);

  localparam int  NUM_SLOTS  = 1 << ADDR_W;
  localparam bit  TIMEOUT_EN = (WAIT_TIMEOUT > 0);
  localparam int  TO_LAST    = (WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0;
  localparam int  CNT_W      = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

  typedef enum logic [3:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY,
    DROP_PACKET
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  wait_cnt;
  logic              addr_err_q;
  logic              timeout_err_q;

  // Per-channel flags widened to the full address space so that any address
  // value indexes a defined bit; unused slots read as "not empty, no reset".
  logic [NUM_SLOTS-1:0] empty_slot;
  logic [NUM_SLOTS-1:0] sreset_slot;
  logic                 addr_ok;

  always_comb begin
    empty_slot  = '0;
    sreset_slot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      empty_slot[i]  = ctrl_if.fifo_empty[i];
      sreset_slot[i] = ctrl_if.soft_reset[i];
    end
  end

  assign addr_ok = (int'(ctrl_if.data_in) < NUM_CH);

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      DECODE_ADDRESS: begin
        if (ctrl_if.pkt_valid) begin
          if (!addr_ok)                          next_state = DROP_PACKET;
          else if (empty_slot[ctrl_if.data_in])  next_state = LOAD_FIRST_DATA;
          else                                   next_state = WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: next_state = LOAD_DATA;
      LOAD_DATA: begin
        // Full takes priority over end-of-packet; parity is then reached
        // through LOAD_AFTER_FULL once low_pkt_valid is seen.
        if (ctrl_if.fifo_full)       next_state = FIFO_FULL_STATE;
        else if (!ctrl_if.pkt_valid) next_state = LOAD_PARITY;
      end
      LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        next_state = ctrl_if.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      FIFO_FULL_STATE: begin
        if (!ctrl_if.fifo_full) next_state = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (ctrl_if.parity_done)        next_state = DECODE_ADDRESS;
        else if (ctrl_if.low_pkt_valid) next_state = LOAD_PARITY;
        else                            next_state = LOAD_DATA;
      end
      WAIT_TILL_EMPTY: begin
        // Destination draining wins over a timeout expiring in the same cycle.
        if (empty_slot[addr])
          next_state = LOAD_FIRST_DATA;
        else if (TIMEOUT_EN && (wait_cnt == CNT_W'(TO_LAST)))
          next_state = DROP_PACKET;
      end
      DROP_PACKET: begin
        if (!ctrl_if.pkt_valid) next_state = DECODE_ADDRESS;
      end
      default: next_state = DECODE_ADDRESS;
    endcase

    // A read-timeout soft reset on the active channel aborts the packet from
    // anywhere a channel is actually selected.
    if ((state != DECODE_ADDRESS) && (state != DROP_PACKET) && sreset_slot[addr])
      next_state = DECODE_ADDRESS;
  end

  // State, latched address, wait counter and error pulses
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= DECODE_ADDRESS;
      addr          <= '0;
      wait_cnt      <= '0;
      addr_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == DECODE_ADDRESS) && ctrl_if.pkt_valid)
        addr <= ctrl_if.data_in;
      // Counts only while remaining in WAIT_TILL_EMPTY, so it is zero on entry.
      if (TIMEOUT_EN && (state == WAIT_TILL_EMPTY) && (next_state == WAIT_TILL_EMPTY))
        wait_cnt <= wait_cnt + CNT_W'(1);
      else
        wait_cnt <= '0;
      addr_err_q    <= (state == DECODE_ADDRESS)  && (next_state == DROP_PACKET);
      timeout_err_q <= (state == WAIT_TILL_EMPTY) && (next_state == DROP_PACKET);
    end
  end

  // Moore decodes
  always_comb begin
    ctrl_if.detect_add    = (state == DECODE_ADDRESS);
    ctrl_if.lfd_state     = (state == LOAD_FIRST_DATA);
    ctrl_if.ld_state      = (state == LOAD_DATA);
    ctrl_if.laf_state     = (state == LOAD_AFTER_FULL);
    ctrl_if.full_state    = (state == FIFO_FULL_STATE);
    ctrl_if.rst_int_reg   = (state == CHECK_PARITY_ERROR);
    ctrl_if.drop_state    = (state == DROP_PACKET);
    ctrl_if.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                            (state == LOAD_AFTER_FULL);
    ctrl_if.busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA) ||
                              (state == DROP_PACKET));
    ctrl_if.ch_sel        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ctrl_if.ch_sel[i] = (state != DECODE_ADDRESS) && (state != DROP_PACKET) &&
                          (int'(addr) == i);
    end
    ctrl_if.addr_err      = addr_err_q;
    ctrl_if.timeout_err   = timeout_err_q;
  end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
module tb_router_ctrl_fsm;

  // Observation vector: {write_enb_reg, busy, drop, rst_int, full, laf, ld, lfd, detect}
  localparam logic [8:0] S_DEC  = 9'b0_0_0000001;
  localparam logic [8:0] S_LFD  = 9'b0_1_0000010;
  localparam logic [8:0] S_LD   = 9'b1_0_0000100;
  localparam logic [8:0] S_LP   = 9'b1_1_0000000;
  localparam logic [8:0] S_CPE  = 9'b0_1_0100000;
  localparam logic [8:0] S_FFS  = 9'b0_1_0010000;
  localparam logic [8:0] S_LAF  = 9'b1_1_0001000;
  localparam logic [8:0] S_WAIT = 9'b0_1_0000000;
  localparam logic [8:0] S_DRP  = 9'b0_0_1000000;

  logic clock;
  logic resetn;
  int   n_checks;
  int   n_pass;

  router_ctrl_fsm_if #(.NUM_CH(3), .ADDR_W(2)) bus_if ();

  router_ctrl_fsm #(.NUM_CH(3), .ADDR_W(2), .WAIT_TIMEOUT(30)) u_dut (
    .clock   (clock),
    .resetn  (resetn),
    .ctrl_if (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [8:0] obs;
  assign obs = {bus_if.write_enb_reg, bus_if.busy, bus_if.drop_state, bus_if.rst_int_reg,
                bus_if.full_state, bus_if.laf_state, bus_if.ld_state, bus_if.lfd_state,
                bus_if.detect_add};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic exp_st(input string tag, input logic [8:0] st, input logic [2:0] ch,
                        input logic [1:0] err);
    chk({tag, ".state"}, 32'(obs), 32'(st));
    chk({tag, ".ch_sel"}, 32'(bus_if.ch_sel), 32'(ch));
    chk({tag, ".err"}, 32'({bus_if.timeout_err, bus_if.addr_err}), 32'(err));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    resetn   = 1'b0;
    bus_if.pkt_valid     = 1'b0;
    bus_if.data_in       = '0;
    bus_if.fifo_full     = 1'b0;
    bus_if.fifo_empty    = 3'b111;
    bus_if.soft_reset    = '0;
    bus_if.parity_done   = 1'b0;
    bus_if.low_pkt_valid = 1'b0;

    // Reset state
    step(); step();
    exp_st("reset", S_DEC, 3'b000, 2'b00);
    resetn = 1'b1;
    step();
    exp_st("idle", S_DEC, 3'b000, 2'b00);

    // Normal packet to channel 1, 4-byte payload
    bus_if.pkt_valid = 1'b1;
    bus_if.data_in   = 2'd1;
    step(); exp_st("p1.lfd", S_LFD, 3'b010, 2'b00);
    for (int i = 0; i < 4; i++) begin
      step(); exp_st("p1.ld", S_LD, 3'b010, 2'b00);
      if (i == 3) bus_if.pkt_valid = 1'b0;
    end
    step(); exp_st("p1.lp", S_LP, 3'b010, 2'b00);
    step(); exp_st("p1.cpe", S_CPE, 3'b010, 2'b00);
    step(); exp_st("p1.dec", S_DEC, 3'b000, 2'b00);

    // Invalid address 3 is dropped
    bus_if.pkt_valid = 1'b1;
    bus_if.data_in   = 2'd3;
    step(); exp_st("bad.drop0", S_DRP, 3'b000, 2'b01);
    step(); exp_st("bad.drop1", S_DRP, 3'b000, 2'b00);
    step(); exp_st("bad.drop2", S_DRP, 3'b000, 2'b00);
    bus_if.pkt_valid = 1'b0;
    step(); exp_st("bad.dec", S_DEC, 3'b000, 2'b00);

    // Busy destination never drains: 30 cycles of wait, then drop
    bus_if.fifo_empty = 3'b011;
    bus_if.pkt_valid  = 1'b1;
    bus_if.data_in    = 2'd2;
    for (int i = 0; i < 30; i++) begin
      step(); exp_st("to.wait", S_WAIT, 3'b100, 2'b00);
    end
    step(); exp_st("to.drop", S_DRP, 3'b000, 2'b10);
    bus_if.pkt_valid = 1'b0;
    step(); exp_st("to.dec", S_DEC, 3'b000, 2'b00);

    // Busy destination drains after 10 wait cycles
    bus_if.pkt_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(); exp_st("dr.wait", S_WAIT, 3'b100, 2'b00);
    end
    bus_if.fifo_empty = 3'b111;
    step(); exp_st("dr.lfd", S_LFD, 3'b100, 2'b00);
    bus_if.pkt_valid = 1'b0;
    step(); exp_st("dr.ld", S_LD, 3'b100, 2'b00);
    step(); exp_st("dr.lp", S_LP, 3'b100, 2'b00);
    step(); exp_st("dr.cpe", S_CPE, 3'b100, 2'b00);
    step(); exp_st("dr.dec", S_DEC, 3'b000, 2'b00);

    // FIFO full for 5 cycles in LOAD_DATA, resume to LOAD_DATA
    bus_if.pkt_valid = 1'b1;
    bus_if.data_in   = 2'd0;
    step(); exp_st("ff.lfd", S_LFD, 3'b001, 2'b00);
    step(); exp_st("ff.ld", S_LD, 3'b001, 2'b00);
    bus_if.fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); exp_st("ff.full", S_FFS, 3'b001, 2'b00);
    end
    bus_if.fifo_full = 1'b0;
    step(); exp_st("ff.laf", S_LAF, 3'b001, 2'b00);
    step(); exp_st("ff.ld2", S_LD, 3'b001, 2'b00);
    // Full again, this time parity_done returns straight to decode
    bus_if.fifo_full = 1'b1;
    step(); exp_st("pd.full", S_FFS, 3'b001, 2'b00);
    bus_if.fifo_full = 1'b0;
    step(); exp_st("pd.laf", S_LAF, 3'b001, 2'b00);
    bus_if.parity_done = 1'b1;
    bus_if.pkt_valid   = 1'b0;
    step(); exp_st("pd.dec", S_DEC, 3'b000, 2'b00);
    bus_if.parity_done = 1'b0;

    // pkt_valid falls together with fifo_full: full path, then low_pkt_valid to parity
    bus_if.pkt_valid = 1'b1;
    step(); exp_st("lv.lfd", S_LFD, 3'b001, 2'b00);
    step(); exp_st("lv.ld", S_LD, 3'b001, 2'b00);
    bus_if.pkt_valid = 1'b0;
    bus_if.fifo_full = 1'b1;
    step(); exp_st("lv.full", S_FFS, 3'b001, 2'b00);
    bus_if.fifo_full     = 1'b0;
    bus_if.low_pkt_valid = 1'b1;
    step(); exp_st("lv.laf", S_LAF, 3'b001, 2'b00);
    step(); exp_st("lv.lp", S_LP, 3'b001, 2'b00);
    bus_if.low_pkt_valid = 1'b0;
    step(); exp_st("lv.cpe", S_CPE, 3'b001, 2'b00);
    step(); exp_st("lv.dec", S_DEC, 3'b000, 2'b00);

    // Soft reset: other channel ignored, active channel aborts
    bus_if.pkt_valid = 1'b1;
    step(); exp_st("sr.lfd", S_LFD, 3'b001, 2'b00);
    step(); exp_st("sr.ld", S_LD, 3'b001, 2'b00);
    bus_if.soft_reset = 3'b100;
    step(); exp_st("sr.other", S_LD, 3'b001, 2'b00);
    bus_if.soft_reset = 3'b001;
    step(); exp_st("sr.own", S_DEC, 3'b000, 2'b00);
    bus_if.soft_reset = 3'b000;
    bus_if.pkt_valid  = 1'b0;
    step(); exp_st("sr.idle", S_DEC, 3'b000, 2'b00);

    // Asynchronous reset while in FIFO_FULL_STATE
    bus_if.pkt_valid = 1'b1;
    bus_if.data_in   = 2'd1;
    step(); exp_st("ar.lfd", S_LFD, 3'b010, 2'b00);
    step(); exp_st("ar.ld", S_LD, 3'b010, 2'b00);
    bus_if.fifo_full = 1'b1;
    step(); exp_st("ar.full", S_FFS, 3'b010, 2'b00);
    #2;
    resetn = 1'b0;
    #1;
    exp_st("ar.reset", S_DEC, 3'b000, 2'b00);
    bus_if.fifo_full = 1'b0;
    bus_if.pkt_valid = 1'b0;
    step();
    resetn = 1'b1;
    step(); exp_st("ar.idle", S_DEC, 3'b000, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
